// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-channel selector with manual capture and masked ascending auto-scan over a valid/ready output
module mux_scan_nto1 #(
    parameter int N_CH  = 16,
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic                  start,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  scan_done
);

    typedef enum logic [1:0] {IDLE, MAN, SCAN, DONE} state_t;

    state_t            state, state_n;
    logic [N_CH-1:0]   mask_q;
    logic [WIDTH-1:0]  ch [N_CH];
    logic [SEL_W-1:0]  first_idx, next_idx, load_idx;
    logic              first_hit, next_hit, load, valid_n, hs;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch[g] = in_bus[g*WIDTH +: WIDTH];
    end

    assign hs        = out_valid && out_ready;
    assign busy      = state != IDLE;
    assign scan_done = state == DONE;

    // priority search: lowest enabled channel in the live mask, and lowest registered-mask channel above out_sel
    always_comb begin
        first_idx = '0;
        first_hit = 1'b0;
        next_idx  = '0;
        next_hit  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = SEL_W'(i);
                first_hit = 1'b1;
            end
            if (mask_q[i] && i > int'(out_sel)) begin
                next_idx = SEL_W'(i);
                next_hit = 1'b1;
            end
        end
    end

    // next-state and capture control; a capture always happens at the edge that arms out_valid
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_idx = sel;
        valid_n  = out_valid;
        case (state)
            IDLE: if (start) begin
                if (!mode) begin
                    state_n = MAN;
                    load    = 1'b1;
                    valid_n = 1'b1;
                end else if (first_hit) begin
                    state_n  = SCAN;
                    load     = 1'b1;
                    load_idx = first_idx;
                    valid_n  = 1'b1;
                end else begin
                    state_n = DONE;
                end
            end
            MAN: if (hs) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
            SCAN: if (hs) begin
                if (next_hit) begin
                    load     = 1'b1;
                    load_idx = next_idx;
                end else begin
                    state_n = DONE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, output beat and sampled mask registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            mask_q    <= '0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            if (load) begin
                out_data <= ch[load_idx];
                out_sel  <= load_idx;
            end
            if (state == IDLE && start) mask_q <= ch_mask;
        end
    end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb_mux_scan_nto1: directed plus randomized checks of mux_scan_nto1 against a beat-queue reference model
module tb_mux_scan_nto1;

    localparam int N = 16;
    localparam int W = 8;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           reset, start, mode, out_ready;
    logic [N*W-1:0] in_bus;
    logic [S-1:0]   sel, out_sel;
    logic [N-1:0]   ch_mask;
    logic [W-1:0]   out_data;
    logic           out_valid, busy, scan_done;
    logic [W-1:0]   chan [N];
    int             vectors = 0;
    int             errors  = 0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.N_CH(N), .WIDTH(W), .SEL_W(S)) dut (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .mode(mode),
        .ch_mask(ch_mask), .start(start), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .scan_done(scan_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus(input bit junk);
        for (int i = 0; i < N; i++) in_bus[i*W +: W] = junk ? W'($urandom) : chan[i];
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, scan_done, 0);
    endtask

    task automatic run_man(input logic [S-1:0] s, input int hold);
        drive_bus(0);
        mode = 0; sel = s; ch_mask = N'($urandom); out_ready = 0; start = 1;
        tick;
        start = 0;
        chk("man_valid", out_valid, 1);
        chk("man_sel", out_sel, s);
        chk("man_data", out_data, chan[s]);
        chk("man_busy", busy, 1);
        for (int c = 0; c < hold; c++) begin
            drive_bus(1);
            start = 1; sel = S'($urandom); mode = 1'($urandom);
            tick;
            chk("man_hold_valid", out_valid, 1);
            chk("man_hold_sel", out_sel, s);
            chk("man_hold_data", out_data, chan[s]);
        end
        start = 0; out_ready = 1;
        drive_bus(0);
        tick;
        out_ready = 0;
        chk_idle("man_end");
    endtask

    task automatic run_scan(input logic [N-1:0] m, input int rmode, input int stop_at = -1);
        int q[$];
        int budget;
        bit r;
        for (int i = 0; i < N; i++) if (m[i]) q.push_back(i);
        drive_bus(0);
        mode = 1; ch_mask = m; sel = S'($urandom); out_ready = 0; start = 1;
        tick;
        start = 0;
        if (q.size() == 0) begin
            chk("empty_valid", out_valid, 0);
            chk("empty_busy", busy, 1);
            chk("empty_done", scan_done, 1);
            tick;
            chk_idle("empty_after");
            return;
        end
        budget = 0;
        while (q.size() > 0 && budget < 400) begin
            budget++;
            chk("scan_valid", out_valid, 1);
            chk("scan_sel", out_sel, q[0]);
            chk("scan_data", out_data, chan[q[0]]);
            chk("scan_done_low", scan_done, 0);
            chk("scan_busy", busy, 1);
            if (q[0] == stop_at) begin
                reset = 1; start = 1; out_ready = 1;
                tick;
                reset = 0; start = 0; out_ready = 0;
                chk("rst_data", out_data, 0);
                chk("rst_sel", out_sel, 0);
                chk_idle("rst");
                tick;
                chk_idle("rst_after");
                return;
            end
            r = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(budget % 2) : 1'($urandom_range(0, 1));
            out_ready = r;
            drive_bus(!r);
            start = 1'($urandom_range(0, 1));
            mode = 1'($urandom); ch_mask = N'($urandom); sel = S'($urandom);
            tick;
            if (r) void'(q.pop_front());
        end
        chk("scan_timeout", q.size(), 0);
        start = 0; out_ready = 0;
        drive_bus(0);
        chk("scan_end_valid", out_valid, 0);
        chk("scan_end_done", scan_done, 1);
        chk("scan_end_busy", busy, 1);
        tick;
        chk_idle("scan_after");
    endtask

    initial begin
        logic [N-1:0] m;
        reset = 1; start = 0; mode = 0; out_ready = 0; sel = '0; ch_mask = '0; in_bus = '0;
        for (int i = 0; i < N; i++) chan[i] = W'(8'hA0 + i);
        tick;
        tick;
        reset = 0;
        chk("reset_data", out_data, 0);
        chk("reset_sel", out_sel, 0);
        chk_idle("reset");
        run_man(4'd5, 3);
        run_scan(16'hFFFF, 0);
        run_scan(16'h8421, 1);
        run_scan(16'h0000, 0);
        run_scan(16'h0080, 1);
        run_scan(16'h8000, 2);
        run_scan(16'hFFFF, 0, 7);
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) chan[i] = W'($urandom);
            case ($urandom_range(0, 3))
                0: run_man(S'($urandom), int'($urandom_range(0, 3)));
                1: run_scan(N'(1) << $urandom_range(0, N - 1), 2);
                default: begin
                    m = N'($urandom);
                    run_scan(($urandom_range(0, 7) == 0) ? '0 : m, 2);
                end
            endcase
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
